// File: rtl/sign_extender.sv
// -----------------------------------------------------------------------------
// sign_extender
//   Streaming width converter: sign- or zero-extends (or narrows) a sample from
//   INPUT_DATA_WIDTH to OUTPUT_DATA_WIDTH bits behind a valid/ready interface
//   built from an output register plus a one-entry skid register.
//
//   Optional feature macro: SIGN_EXTENDER_SATURATE_EN
//     defined   - on narrowing overflow, o_data clamps to the output range
//     undefined - on narrowing, o_data is the truncated low bits
//   o_overflow is reported in both builds.
//
// Ports
//   i_clk       rising-edge clock
//   i_rst_n     asynchronous active-low reset
//   i_data      input sample (two's complement unless i_unsigned)
//   i_valid     i_data valid
//   o_ready     block can accept a sample (skid register empty)
//   i_unsigned  1 = zero-extend / unsigned range; travels with its sample
//   o_data      converted sample
//   o_valid     o_data valid
//   i_ready     downstream accepts o_data
//   o_overflow  narrowing altered the value of o_data
// -----------------------------------------------------------------------------
module sign_extender #(
    parameter int INPUT_DATA_WIDTH  = 8,
    parameter int OUTPUT_DATA_WIDTH = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [INPUT_DATA_WIDTH-1:0]  i_data,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic                         i_unsigned,
    output logic [OUTPUT_DATA_WIDTH-1:0] o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic                         o_overflow
);

    localparam int IW = INPUT_DATA_WIDTH;
    localparam int OW = OUTPUT_DATA_WIDTH;

    logic [OW-1:0] w_conv;
    logic          w_ovf;

    // Conversion of the incoming sample; the result is what gets stored.
    generate
        if (OW > IW) begin : g_widen
            logic w_fill;
            assign w_fill = ~i_unsigned & i_data[IW-1];
            assign w_conv = {{(OW-IW){w_fill}}, i_data};
            assign w_ovf  = 1'b0;
        end else if (OW == IW) begin : g_equal
            logic w_unused_sign;
            assign w_unused_sign = i_unsigned;
            assign w_conv        = i_data;
            assign w_ovf         = 1'b0;
        end else begin : g_narrow
            // Signed: discarded bits plus retained MSB must all agree.
            logic [IW-OW:0] w_upper;
            logic           w_ovf_s;
            logic           w_ovf_u;
            assign w_upper = i_data[IW-1:OW-1];
            assign w_ovf_s = ~((&w_upper) | ~(|w_upper));
            assign w_ovf_u = |i_data[IW-1:OW];
            assign w_ovf   = i_unsigned ? w_ovf_u : w_ovf_s;
`ifdef SIGN_EXTENDER_SATURATE_EN
            always_comb begin
                w_conv = i_data[OW-1:0];
                if (w_ovf) begin
                    if (i_unsigned)
                        w_conv = '1;
                    else if (i_data[IW-1])
                        w_conv = {1'b1, {(OW-1){1'b0}}};
                    else
                        w_conv = {1'b0, {(OW-1){1'b1}}};
                end
            end
`else
            assign w_conv = i_data[OW-1:0];
`endif
        end
    endgenerate

    logic [OW-1:0] r_out_data;
    logic          r_out_ovf;
    logic          r_out_valid;
    logic [OW-1:0] r_skid_data;
    logic          r_skid_ovf;
    logic          r_skid_valid;
    logic          r_init;

    logic w_in_xfer;
    logic w_out_free;

    // r_init keeps o_ready low during reset and for the release cycle.
    assign o_ready    = r_init & ~r_skid_valid;
    assign w_in_xfer  = i_valid & o_ready;
    assign w_out_free = ~r_out_valid | i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_init       <= 1'b0;
            r_out_data   <= '0;
            r_out_ovf    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_skid_data  <= '0;
            r_skid_ovf   <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            r_init <= 1'b1;
            if (w_out_free) begin
                // A full skid implies o_ready=0, so no new sample competes.
                if (r_skid_valid) begin
                    r_out_data   <= r_skid_data;
                    r_out_ovf    <= r_skid_ovf;
                    r_out_valid  <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else if (w_in_xfer) begin
                    r_out_data  <= w_conv;
                    r_out_ovf   <= w_ovf;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_in_xfer) begin
                r_skid_data  <= w_conv;
                r_skid_ovf   <= w_ovf;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign o_data     = r_out_data;
    assign o_valid    = r_out_valid;
    assign o_overflow = r_out_ovf;

endmodule

// File: tb/tb_sign_extender.sv
module tb_sign_extender;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // a: 8 -> 16
    logic [7:0]  a_data = '0;
    logic        a_valid = 1'b0, a_uns = 1'b0, a_iready = 1'b1;
    logic        a_oready, a_ovalid, a_ovf;
    logic [15:0] a_odata;
    // b: 16 -> 8
    logic [15:0] b_data = '0;
    logic        b_valid = 1'b0, b_uns = 1'b0, b_iready = 1'b1;
    logic        b_oready, b_ovalid, b_ovf;
    logic [7:0]  b_odata;
    // c: 12 -> 12
    logic [11:0] c_data = '0;
    logic        c_valid = 1'b0, c_uns = 1'b0, c_iready = 1'b1;
    logic        c_oready, c_ovalid, c_ovf;
    logic [11:0] c_odata;

    sign_extender #(.INPUT_DATA_WIDTH(8), .OUTPUT_DATA_WIDTH(16)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(a_data), .i_valid(a_valid),
        .o_ready(a_oready), .i_unsigned(a_uns), .o_data(a_odata),
        .o_valid(a_ovalid), .i_ready(a_iready), .o_overflow(a_ovf));

    sign_extender #(.INPUT_DATA_WIDTH(16), .OUTPUT_DATA_WIDTH(8)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(b_data), .i_valid(b_valid),
        .o_ready(b_oready), .i_unsigned(b_uns), .o_data(b_odata),
        .o_valid(b_ovalid), .i_ready(b_iready), .o_overflow(b_ovf));

    sign_extender #(.INPUT_DATA_WIDTH(12), .OUTPUT_DATA_WIDTH(12)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(c_data), .i_valid(c_valid),
        .o_ready(c_oready), .i_unsigned(c_uns), .o_data(c_odata),
        .o_valid(c_ovalid), .i_ready(c_iready), .o_overflow(c_ovf));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        #2;
        n_checks++;
        if (a_ovalid !== 1'b0 || a_odata !== 16'h0000 || a_ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: valid=%b data=%h ovf=%b, want 0/0000/0", a_ovalid, a_odata, a_ovf);
        end
        n_checks++;
        if (a_oready !== 1'b0 || b_oready !== 1'b0 || c_oready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ready_low: ready a/b/c=%b%b%b, want 000", a_oready, b_oready, c_oready);
        end
        tick();
        tick();
        n_checks++;
        if (a_oready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ready_held: ready=%b, want 0", a_oready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (a_oready !== 1'b1 || b_oready !== 1'b1 || c_oready !== 1'b1 || a_ovalid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: ready a/b/c=%b%b%b valid=%b, want 111 0", a_oready, b_oready, c_oready, a_ovalid);
        end
    endtask

    task automatic test_sign_extend();
        logic [7:0]  vb;
        logic [15:0] exp;
        a_uns = 1'b0;
        a_iready = 1'b1;
        for (int unsigned v = 0; v < 256; v++) begin
            vb = v[7:0];
            a_data = vb;
            a_valid = 1'b1;
            tick();
            exp = {{8{vb[7]}}, vb};
            n_checks++;
            if (a_ovalid !== 1'b1 || a_odata !== exp || a_ovf !== 1'b0 || a_oready !== 1'b1) begin
                n_errors++;
                $display("FAIL sweep_%0d: valid=%b data=%h ovf=%b ready=%b, want 1/%h/0/1", v, a_ovalid, a_odata, a_ovf, a_oready, exp);
            end
            if (vb == 8'h7F || vb == 8'h80 || vb == 8'hFF) begin
                n_checks++;
                if ((vb == 8'h7F && a_odata !== 16'h007F) || (vb == 8'h80 && a_odata !== 16'hFF80) ||
                    (vb == 8'hFF && a_odata !== 16'hFFFF)) begin
                    n_errors++;
                    $display("FAIL sweep_point_%h: data=%h", vb, a_odata);
                end
            end
        end
        a_valid = 1'b0;
        tick();
        n_checks++;
        if (a_ovalid !== 1'b0) begin
            n_errors++;
            $display("FAIL sweep_drain: valid=%b, want 0", a_ovalid);
        end
    endtask

    task automatic test_unsigned();
        logic [7:0]  din [3];
        logic        uns [3];
        logic [15:0] exp [3];
        din[0] = 8'h80; uns[0] = 1'b1; exp[0] = 16'h0080;
        din[1] = 8'hFF; uns[1] = 1'b1; exp[1] = 16'h00FF;
        din[2] = 8'h80; uns[2] = 1'b0; exp[2] = 16'hFF80;
        a_iready = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            a_data = din[i];
            a_uns = uns[i];
            a_valid = 1'b1;
            tick();
            n_checks++;
            if (a_ovalid !== 1'b1 || a_odata !== exp[i] || a_ovf !== 1'b0) begin
                n_errors++;
                $display("FAIL unsigned_%0d: valid=%b data=%h ovf=%b, want 1/%h/0", i, a_ovalid, a_odata, a_ovf, exp[i]);
            end
        end
        a_valid = 1'b0;
        a_uns = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [7:0]  din  [8];
        logic        ird  [8];
        logic        vld  [8];
        logic [15:0] exp  [8];
        logic        evld [8];
        logic        erdy [8];
        int          acc = 0;
        // A=0x11, B=0x82, C=0x33; i_ready low for steps 0..4
        din[0]=8'h11; ird[0]=0; vld[0]=1; exp[0]=16'h0011; evld[0]=1; erdy[0]=1;
        din[1]=8'h82; ird[1]=0; vld[1]=1; exp[1]=16'h0011; evld[1]=1; erdy[1]=0;
        din[2]=8'h33; ird[2]=0; vld[2]=1; exp[2]=16'h0011; evld[2]=1; erdy[2]=0;
        din[3]=8'h33; ird[3]=0; vld[3]=1; exp[3]=16'h0011; evld[3]=1; erdy[3]=0;
        din[4]=8'h33; ird[4]=0; vld[4]=1; exp[4]=16'h0011; evld[4]=1; erdy[4]=0;
        din[5]=8'h33; ird[5]=1; vld[5]=1; exp[5]=16'hFF82; evld[5]=1; erdy[5]=1;
        din[6]=8'h33; ird[6]=1; vld[6]=1; exp[6]=16'h0033; evld[6]=1; erdy[6]=1;
        din[7]=8'h00; ird[7]=1; vld[7]=0; exp[7]=16'h0033; evld[7]=0; erdy[7]=1;
        for (int unsigned s = 0; s < 8; s++) begin
            a_data = din[s];
            a_iready = ird[s];
            a_valid = vld[s];
            if (s < 5 && a_valid && a_oready) acc++;
            tick();
            n_checks++;
            if (a_ovalid !== evld[s] || a_oready !== erdy[s] || (evld[s] && a_odata !== exp[s])) begin
                n_errors++;
                $display("FAIL backpressure_%0d: valid=%b ready=%b data=%h, want %b/%b/%h", s, a_ovalid, a_oready, a_odata, evld[s], erdy[s], exp[s]);
            end
            if (s == 4) begin
                n_checks++;
                if (acc != 2) begin
                    n_errors++;
                    $display("FAIL backpressure_accepted: got %0d, want 2", acc);
                end
            end
        end
    endtask

    task automatic test_narrow();
        logic [15:0] din [8];
        logic        uns [8];
        logic [7:0]  exp [8];
        logic        eov [8];
`ifdef SIGN_EXTENDER_SATURATE_EN
        din[0]=16'h0100; uns[0]=0; exp[0]=8'h7F; eov[0]=1;
        din[1]=16'hFF00; uns[1]=0; exp[1]=8'h80; eov[1]=1;
        din[4]=16'h0080; uns[4]=0; exp[4]=8'h7F; eov[4]=1;
        din[5]=16'h0100; uns[5]=1; exp[5]=8'hFF; eov[5]=1;
`else
        din[0]=16'h0100; uns[0]=0; exp[0]=8'h00; eov[0]=1;
        din[1]=16'hFF00; uns[1]=0; exp[1]=8'h00; eov[1]=1;
        din[4]=16'h0080; uns[4]=0; exp[4]=8'h80; eov[4]=1;
        din[5]=16'h0100; uns[5]=1; exp[5]=8'h00; eov[5]=1;
`endif
        din[2]=16'hFFF0; uns[2]=0; exp[2]=8'hF0; eov[2]=0;
        din[3]=16'h007F; uns[3]=0; exp[3]=8'h7F; eov[3]=0;
        din[6]=16'h00FF; uns[6]=1; exp[6]=8'hFF; eov[6]=0;
        din[7]=16'hFF80; uns[7]=0; exp[7]=8'h80; eov[7]=0;
        b_iready = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            b_data = din[i];
            b_uns = uns[i];
            b_valid = 1'b1;
            tick();
            n_checks++;
            if (b_ovalid !== 1'b1 || b_odata !== exp[i] || b_ovf !== eov[i]) begin
                n_errors++;
                $display("FAIL narrow_%h_u%0d: valid=%b data=%h ovf=%b, want 1/%h/%b", din[i], uns[i], b_ovalid, b_odata, b_ovf, exp[i], eov[i]);
            end
        end
        b_valid = 1'b0;
        tick();
    endtask

    task automatic test_equal();
        logic [11:0] din [4];
        logic        uns [4];
        din[0]=12'h800; uns[0]=0;
        din[1]=12'h7FF; uns[1]=0;
        din[2]=12'h800; uns[2]=1;
        din[3]=12'hFFF; uns[3]=0;
        c_iready = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            c_data = din[i];
            c_uns = uns[i];
            c_valid = 1'b1;
            tick();
            n_checks++;
            if (c_ovalid !== 1'b1 || c_odata !== din[i] || c_ovf !== 1'b0) begin
                n_errors++;
                $display("FAIL equal_%h: valid=%b data=%h ovf=%b, want 1/%h/0", din[i], c_ovalid, c_odata, c_ovf, din[i]);
            end
        end
        c_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_midstream();
        a_iready = 1'b0;
        a_uns = 1'b0;
        a_valid = 1'b1;
        a_data = 8'h91;
        tick();
        a_data = 8'h92;
        tick();
        a_valid = 1'b0;
        n_checks++;
        if (a_ovalid !== 1'b1 || a_oready !== 1'b0 || a_odata !== 16'hFF91) begin
            n_errors++;
            $display("FAIL midreset_full: valid=%b ready=%b data=%h, want 1/0/ff91", a_ovalid, a_oready, a_odata);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (a_ovalid !== 1'b0 || a_odata !== 16'h0000 || a_ovf !== 1'b0 || a_oready !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_clear: valid=%b data=%h ovf=%b ready=%b, want 0/0000/0/0", a_ovalid, a_odata, a_ovf, a_oready);
        end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        a_iready = 1'b1;
        tick();
        n_checks++;
        if (a_oready !== 1'b1 || a_ovalid !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_release: ready=%b valid=%b, want 1/0", a_oready, a_ovalid);
        end
        tick();
        n_checks++;
        if (a_ovalid !== 1'b0 || a_odata !== 16'h0000) begin
            n_errors++;
            $display("FAIL midreset_stale: valid=%b data=%h, want 0/0000", a_ovalid, a_odata);
        end
    endtask

    initial begin
        test_reset();
        test_sign_extend();
        test_unsigned();
        test_backpressure();
        test_narrow();
        test_equal();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sign_extender.md
# sign_extender

Streaming width converter that takes a signed (or optionally unsigned) sample of INPUT_DATA_WIDTH bits and presents it as OUTPUT_DATA_WIDTH bits with correct sign/zero extension. If the output is narrower than the input, the block narrows the sample. It sits in the DPM datapath between narrow ADC/NCO-style sources and wider accumulators/filters. It has a registered valid/ready interface so it can be dropped between any two streaming stages.

## Interface
- INPUT_DATA_WIDTH, 8, width of i_data (≥2)
- OUTPUT_DATA_WIDTH, 16, width of o_data (≥2; may be <, =, > INPUT_DATA_WIDTH)
- i_clk  input  1  rising-edge clock
- i_rst_n  input  1  reset; asynchronous, active-low
- i_data  input  INPUT_DATA_WIDTH  input sample, two's complement unless i_unsigned
- i_valid  input  1  i_data valid
- o_ready  output  1  block can accept a sample this cycle
- i_unsigned  input  1  1 = treat i_data as unsigned (zero-extend); sampled with i_data
- o_data  output  OUTPUT_DATA_WIDTH  converted sample
- o_valid  output  1  o_data valid
- i_ready  input  1  downstream accepts o_data
- o_overflow  output  1  set with o_data when narrowing altered the value

## Operation
- Input transfer on i_valid && o_ready; output transfer on o_valid && i_ready.
- Widening/equal (OUT ≥ IN): o_data = {(OUT−IN) copies of i_data[IN−1], i_data} when signed, or zero-padded when i_unsigned. o_overflow = 0 always.
- Narrowing (OUT < IN): the behaviour is selected by the Configuration macro. o_overflow = 1 when the discarded upper bits are not all equal to the retained MSB (signed), or not all zero (unsigned).
- Internally there is a one-entry output register plus a one-entry skid register. This gives full throughput (one sample per clock) under continuous i_ready, and no combinational path from i_ready to o_ready.
- o_ready = skid register empty.
- If the output register is empty, or being drained, the incoming sample goes to the output register. Otherwise it goes to the skid register. The skid register refills the output register when the output register drains.
- Ordering is strictly FIFO. No sample is dropped or duplicated.
- i_unsigned travels with its sample. Changing i_unsigned between samples affects only later samples.

## Timing
- Reset (asynchronous assert, synchronous-release-safe): o_valid = 0, o_data = 0, o_overflow = 0, skid empty, o_ready = 1 one cycle after deassertion. o_ready is held 0 while i_rst_n = 0.
- Latency: the input transfer at edge N gives o_valid = 1 with the converted o_data after edge N (one-cycle latency).
- With i_ready held 1 and i_valid held 1: one output per clock, o_ready stays 1.
- With i_ready = 0: one sample is accepted into the output register and a second into the skid register, then o_ready = 0. o_data and o_overflow stay stable while o_valid && !i_ready.
- Simultaneous input and output transfer with the skid register empty: the output register is replaced with the new sample, with no bubble.
- Reset mid-stream discards both entries immediately.

## Configuration
- SIGN_EXTENDER_SATURATE_EN defined: on narrowing overflow, o_data clamps to the output range.
  - Signed: max 2^(OUT−1)−1 and min −2^(OUT−1).
  - Unsigned: 2^OUT−1.
- Undefined: on narrowing, o_data = i_data[OUT−1:0] (wrap/truncate), and o_overflow is still reported.
- The macro has no effect when OUT ≥ IN.

## Test plan
- IN=8, OUT=16, signed, i_ready=1: sweep i_data 0..255 continuously. Required outputs: 0x7F→0x007F, 0x80→0xFF80, 0xFF→0xFFFF. One output per clock, 1-cycle latency, o_overflow=0.
- IN=8, OUT=16, i_unsigned=1: i_data 0x80→0x0080, 0xFF→0x00FF.
- Backpressure: i_ready=0 for 5 cycles while driving 3 samples. Exactly 2 are accepted and o_ready falls. After i_ready=1, the outputs appear in order with no loss.
- IN=16, OUT=8, signed, macro defined: 0x0100→0x7F with ovf=1; 0xFF00→0x80 with ovf=1; 0xFFF0→0xF0 with ovf=0. Macro undefined: 0x0100→0x00 with ovf=1.
- Assert i_rst_n=0 with both entries full. o_valid and o_data go to 0 immediately. After release, o_ready=1 and there is no stale output.
- IN=OUT=12: data passes unchanged for 0x800 and 0x7FF, with ovf=0.
